dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-port 64x16 data memory between the CPU core's load/store path and an external host port (loader/debug). It sits between the core datapath and the data memory macro and drives the macro's active-low `csb0`/`web0` controls. It issues at most one access per cycle and returns read data with the macro's one-cycle latency. A starvation counter and a host-lock state machine guarantee host progress and let the host freeze core memory traffic.

## Interface
- `ADDR_W`, 6: memory address width.
- `DATA_W`, 16: data width.
- `HOST_MAX_WAIT`, 4: consecutive denied host cycles before the host is forced ahead of the core; legal range 1..15.

- `clk0`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `core_req`  in  1  core requests an access this cycle.
- `core_we`  in  1  1 = write, 0 = read.
- `core_addr`  in  ADDR_W  core address.
- `core_wdata`  in  DATA_W  core write data.
- `core_gnt`  out  1  core access issued this cycle (combinational).
- `core_stall`  out  1  core_req present but not granted (combinational).
- `core_rvalid`  out  1  core read data valid (registered).
- `core_rdata`  out  DATA_W  read data, qualified by `core_rvalid`.
- `host_req`, `host_we`, `host_addr`, `host_wdata`  in  1/1/ADDR_W/DATA_W  host request, same meaning as core.
- `host_lock`  in  1  level request to exclude the core.
- `host_gnt`  out  1  host access issued this cycle.
- `host_rvalid`  out  1  host read data valid.
- `host_rdata`  out  DATA_W  read data, qualified by `host_rvalid`.
- `locked`  out  1  FSM in HOLD (registered).
- `mem_csb0`  out  1  macro chip select, active low.
- `mem_web0`  out  1  macro write enable, active low.
- `mem_addr0`  out  ADDR_W  macro address.
- `mem_din0`  out  DATA_W  macro write data.
- `mem_dout0`  in  DATA_W  macro read data, valid one cycle after read issue.

## Operation
- FSM states: RUN, HOLD. Reset enters RUN.
  - RUN -> HOLD on any edge where `host_lock` = 1.
  - HOLD -> RUN on any edge where `host_lock` = 0.
- In HOLD, `core_gnt` = 0. `host_req` is granted every cycle.
- In RUN, grant is decided as follows:
  - Only one requester: that requester is granted.
  - Both requesting, `wait_cnt` < HOST_MAX_WAIT: core is granted.
  - Both requesting, `wait_cnt` == HOST_MAX_WAIT: host is granted.
- `wait_cnt` (4-bit) updates on each edge:
  - Cleared when `host_req` = 0 or the host is granted.
  - Otherwise incremented, saturating at HOST_MAX_WAIT.
- At most one of `core_gnt`/`host_gnt` is 1 in any cycle.
- Memory drive:
  - A granted requester's `addr`, `wdata` and `we` drive `mem_addr0`, `mem_din0` and `mem_web0` (`mem_web0` = ~we).
  - `mem_csb0` = 0 only when a grant is issued.
  - With no grant: `mem_csb0` = 1, `mem_web0` = 1, `mem_addr0`/`mem_din0` = 0.
- Read tracking:
  - A registered owner tag records each granted read.
  - `core_rvalid`/`host_rvalid` pulse for exactly one cycle, one cycle after the read grant.
  - `*_rdata` = `mem_dout0` while the corresponding rvalid = 1, else 0.
  - Writes produce no rvalid.
- Requesters must hold request fields stable until granted. No request buffering in the arbiter.

## Timing
- Reset values: `core_gnt`, `host_gnt`, `core_stall`, `core_rvalid`, `host_rvalid`, `locked` = 0; `*_rdata` = 0; `mem_csb0` = 1; `mem_web0` = 1; `mem_addr0` = 0, `mem_din0` = 0; `wait_cnt` = 0; FSM = RUN.
- While `reset` = 1, all grants are forced to 0 regardless of requests.
- Grant latency: 0 cycles; the grant is combinational from request and registered state.
- Read latency: 1 cycle from grant to rvalid.
- Write: committed at the grant edge.
- Reset mid-operation: a read granted in the cycle before reset does not produce rvalid after reset. The owner tag is cleared.
- `host_lock` rising at cycle N: the core may still be granted in cycle N. From cycle N+1, `locked` = 1 and the core is never granted.
- Core read and host read back-to-back (cycle N core, cycle N+1 host): `core_rvalid` at N+1 and `host_rvalid` at N+2, with no overlap.

## Test plan
- Reset: hold `reset` 2 cycles with both requests high -> no grants, `mem_csb0` = 1, `mem_web0` = 1, all rvalid = 0, `locked` = 0.
- Core alone: write addr 5 = 0xBEEF, next cycle read addr 5 -> `core_gnt` both cycles; `core_rvalid` = 1 and `core_rdata` = 0xBEEF one cycle after the read.
- Contention, HOST_MAX_WAIT = 4, both requesting continuously from cycle 0 -> core granted cycles 0-3, host cycle 4, core 5-8, host 9; `core_stall` = 1 exactly in cycles 4 and 9.
- Lock: assert `host_lock` at cycle 10 with `core_req` = 1 -> core may be granted at 10; `locked` = 1 and `core_gnt` = 0 from cycle 11; host writes addr 0..3 in 4 consecutive cycles; deassert -> core granted one cycle after `locked` falls.
- Reset mid-read: host read granted at cycle N, `reset` = 1 at N+1 -> `host_rvalid` stays 0 at N+1 and N+2.
- Write/read ordering: host write addr 1 = 0x1234 at cycle N (core held off), core read addr 1 at N+1 -> `core_rdata` = 0x1234 at N+2.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store path and the host port.
// Host wins after HOST_MAX_WAIT denied cycles; host_lock freezes core traffic (HOLD state, shown on `locked`).
module dmem_arbiter #(
  parameter int ADDR_W        = 6,
  parameter int DATA_W        = 16,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic              clk0,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              locked,
  output logic              mem_csb0,
  output logic              mem_web0,
  output logic [ADDR_W-1:0] mem_addr0,
  output logic [DATA_W-1:0] mem_din0,
  input  logic [DATA_W-1:0] mem_dout0
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

  logic [0:0] state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       rd_core_q, rd_core_d;
  logic       rd_host_q, rd_host_d;

  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    if (!reset) begin
      if (state_q == ST_HOLD) begin
        host_gnt = host_req;
      end else if (core_req && host_req) begin
        host_gnt = (wait_cnt_q == MAX_WAIT);
        core_gnt = (wait_cnt_q != MAX_WAIT);
      end else begin
        core_gnt = core_req;
        host_gnt = host_req;
      end
    end
  end

  assign core_stall = core_req && !core_gnt && !reset;
  assign locked     = (state_q == ST_HOLD);

  always_comb begin
    mem_csb0  = 1'b1;
    mem_web0  = 1'b1;
    mem_addr0 = '0;
    mem_din0  = '0;
    if (host_gnt) begin
      mem_csb0  = 1'b0;
      mem_web0  = ~host_we;
      mem_addr0 = host_addr;
      mem_din0  = host_wdata;
    end else if (core_gnt) begin
      mem_csb0  = 1'b0;
      mem_web0  = ~core_we;
      mem_addr0 = core_addr;
      mem_din0  = core_wdata;
    end
  end

  always_comb begin
    state_d = host_lock ? ST_HOLD : ST_RUN;
    if (!host_req || host_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q >= MAX_WAIT) begin
      wait_cnt_d = MAX_WAIT;
    end else begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    rd_core_d = core_gnt && !core_we;
    rd_host_d = host_gnt && !host_we;
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 4'd0;
      rd_core_q  <= 1'b0;
      rd_host_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rd_core_q  <= rd_core_d;
      rd_host_q  <= rd_host_d;
    end
  end

  // Reset kills a read issued the cycle before, even though its owner tag is still set.
  assign core_rvalid = rd_core_q && !reset;
  assign host_rvalid = rd_host_q && !reset;
  assign core_rdata  = core_rvalid ? mem_dout0 : '0;
  assign host_rdata  = host_rvalid ? mem_dout0 : '0;

endmodule
